// File: rtl/alu_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_pkg
// Shared definitions for the ALU operation sequencer:
//   - 4-bit ALU opcode constants (0..15)
//   - bit positions of the {C,N,V,Z} condition-code nibble
//   - sequencer state encoding
//   - helper classifying the single-bit shift/rotate opcodes
// -----------------------------------------------------------------------------
package alu_op_sequencer_pkg;

    localparam int OPCODE_W = 4;
    localparam int CC_W     = 4;

    // ALU opcodes
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_ADDC = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_NAND = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_XNOR = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_LSL  = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_LSR  = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_RL   = 4'd11;
    localparam logic [OPCODE_W-1:0] OP_RR   = 4'd12;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'd13;
    localparam logic [OPCODE_W-1:0] OP_TWOC = 4'd14;
    localparam logic [OPCODE_W-1:0] OP_PASS = 4'd15;

    // Condition-code bit positions inside {C,N,V,Z}
    localparam int CC_C = 3;
    localparam int CC_N = 2;
    localparam int CC_V = 1;
    localparam int CC_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // The ALU only moves one bit position per cycle for these opcodes,
    // so the sequencer has to iterate them.
    function automatic logic is_shift_op(input logic [OPCODE_W-1:0] o);
        return (o >= OP_LSL) && (o <= OP_RR);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_shift_iter_counter.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_shift_iter_counter
// Loadable down-counter tracking the remaining single-bit shift steps.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; clears the count
//   load     in   load load_val (has priority over dec)
//   load_val in   SHAMT_W  number of iterations to perform
//   dec      in   decrement by one (saturates at zero, never wraps)
//   zero     out  count == 0
//   last     out  count == 1, i.e. the current step is the final one
// -----------------------------------------------------------------------------
module alu_op_sequencer_shift_iter_counter #(
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [SHAMT_W-1:0] load_val,
    input  logic               dec,
    output logic               zero,
    output logic               last
);

    logic [SHAMT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - SHAMT_W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == SHAMT_W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Multi-cycle controller placed in front of the combinational 32-bit ALU.
// Accepts one operation per start/ready handshake, drives the ALU ports from
// its own registers, iterates single-bit shift/rotate opcodes to reach an
// N-position shift, and owns the architectural condition-code register.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   start / ready       request handshake; accept when start && ready
//   op, opa, opb        operation and operands (latched on accept)
//   shamt               shift distance for LSL/LSR/RL/RR
//   update_cc           commit ALU flags to cc when the operation finishes
//   cc_wr, cc_wdata     direct {C,N,V,Z} load, honoured only while idle
//   done                one-cycle pulse, result valid
//   result              final result, held until the next done
//   cc                  registered {C,N,V,Z}
//   alu_a/b/cin/op      to the ALU instance
//   alu_result/flags    from the ALU instance
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OPCODE_W-1:0] op,
    input  logic [DATA_W-1:0]   opa,
    input  logic [DATA_W-1:0]   opb,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic                update_cc,
    input  logic                cc_wr,
    input  logic [CC_W-1:0]     cc_wdata,
    output logic                ready,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic [CC_W-1:0]     cc,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic                alu_cin,
    output logic [OPCODE_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [CC_W-1:0]     alu_flags
);

    seq_state_e          state;
    seq_state_e          next_state;

    logic [OPCODE_W-1:0] work_op;
    logic [DATA_W-1:0]   work_a;
    logic [DATA_W-1:0]   work_b;
    logic                work_upd;

    logic [DATA_W-1:0]   result_r;
    logic [CC_W-1:0]     cc_r;

    logic                accept;
    logic                start_iter;
    logic                cnt_zero;
    logic                cnt_last;
    logic                final_cycle;

    assign accept     = start && (state == ST_IDLE);
    // A shift by zero takes the plain EXEC path as a PASS.
    assign start_iter = is_shift_op(op) && (shamt != '0);

    alu_op_sequencer_shift_iter_counter #(
        .SHAMT_W (SHAMT_W)
    ) u_shift_iter_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && start_iter),
        .load_val (shamt),
        .dec      (state == ST_ITER),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // The last ALU cycle of an operation: the only point where the result
    // and (optionally) the flags are committed. cnt_zero in ITER cannot
    // occur in normal flow; treating it as final keeps the FSM from sticking.
    assign final_cycle = (state == ST_EXEC) ||
                         ((state == ST_ITER) && (cnt_last || cnt_zero));

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (accept) next_state = start_iter ? ST_ITER : ST_EXEC;
            ST_EXEC: next_state = ST_DONE;
            ST_ITER: if (cnt_last || cnt_zero) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Control and architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            result_r <= '0;
            cc_r     <= '0;
            work_upd <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                work_upd <= update_cc;
            end
            if (final_cycle) begin
                result_r <= alu_result;
                if (work_upd) begin
                    cc_r <= alu_flags;
                end
            end else if ((state == ST_IDLE) && cc_wr) begin
                // Written in the accept cycle too, so a following ADDC
                // consumes the restored carry.
                cc_r <= cc_wdata;
            end
        end
    end

    // Work registers: data only, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            work_op <= (is_shift_op(op) && (shamt == '0)) ? OP_PASS : op;
            work_a  <= opa;
            work_b  <= opb;
        end else if (state == ST_ITER) begin
            // Feed each single-bit step back as the next operand.
            work_a <= alu_result;
        end
    end

    // ALU drive decoded from state and work registers only
    always_comb begin
        alu_op  = OP_PASS;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        if ((state == ST_EXEC) || (state == ST_ITER)) begin
            alu_op  = work_op;
            alu_a   = work_a;
            alu_b   = work_b;
            alu_cin = cc_r[CC_C];
        end
    end

    assign ready  = (state == ST_IDLE);
    assign done   = (state == ST_DONE);
    assign result = result_r;
    assign cc     = cc_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Drives alu_op_sequencer with directed and random operations. A behavioural
// ALU closes the loop on the alu_* ports; expected results come from
// whole-distance shift arithmetic and a condition-code shadow.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic        update_cc;
    logic        cc_wr;
    logic [3:0]  cc_wdata;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic [3:0]  cc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  ccm;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .shamt      (shamt),
        .update_cc  (update_cc),
        .cc_wr      (cc_wr),
        .cc_wdata   (cc_wdata),
        .ready      (ready),
        .done       (done),
        .result     (result),
        .cc         (cc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_flags  (alu_flags)
    );

    // Behavioural 32-bit ALU: returns {C,N,V,Z,result}
    function automatic logic [35:0] alu_fn(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (o)
            4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                         v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1:  begin s = {1'b0, a} + {1'b0, b} + {32'd0, ci}; r = s[31:0]; c = s[32];
                         v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd2:  begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                         v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd3:  r = a & b;
            4'd4:  r = ~(a & b);
            4'd5:  r = a | b;
            4'd6:  r = ~(a | b);
            4'd7:  r = a ^ b;
            4'd8:  r = ~(a ^ b);
            4'd9:  begin r = {a[30:0], 1'b0};  c = a[31]; end
            4'd10: begin r = {1'b0, a[31:1]};  c = a[0];  end
            4'd11: begin r = {a[30:0], a[31]}; c = a[31]; end
            4'd12: begin r = {a[0], a[31:1]};  c = a[0];  end
            4'd13: r = ~a;
            4'd14: begin r = ~a + 32'd1; v = (a == 32'h8000_0000); end
            default: r = a;
        endcase
        return {c, r[31], v, (r == 32'd0), r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

    // Whole-distance shift/rotate reference
    function automatic logic [31:0] shift_ref(input logic [3:0] o, input logic [31:0] a, input int n);
        logic [63:0] d;
        d = {a, a};
        case (o)
            4'd9:  return a << n;
            4'd10: return a >> n;
            4'd11: begin d = d << n; return d[63:32]; end
            4'd12: begin d = d >> n; return d[31:0];  end
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation through the handshake. hold keeps start high while busy;
    // noisy drives cc_wr while busy (must be ignored).
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic upd, input logic wr, input logic [3:0] wd,
                         input bit hold, input bit noisy,
                         output logic [31:0] res_o, output int lat_o);
        logic [31:0] er;
        logic [3:0]  ef;
        logic [35:0] fr;
        logic        cin;
        int          exp_lat;
        int          lat;
        int          busy_ready;
        bit          seen;
        @(negedge clk);
        check("idle_ready", {63'd0, ready}, 64'd1);
        start = 1'b1; op = o; opa = a; opb = b; shamt = 5'(n);
        update_cc = upd; cc_wr = wr; cc_wdata = wd;
        if (wr) ccm = wd;
        cin = ccm[3];
        if ((o >= 4'd9) && (o <= 4'd12) && (n != 0)) begin
            er = shift_ref(o, a, n);
            fr = alu_fn(o, shift_ref(o, a, n - 1), b, cin);
            exp_lat = n + 1;
        end else if ((o >= 4'd9) && (o <= 4'd12)) begin
            er = a;
            fr = alu_fn(4'd15, a, b, cin);
            exp_lat = 2;
        end else begin
            fr = alu_fn(o, a, b, cin);
            er = fr[31:0];
            exp_lat = 2;
        end
        ef = fr[35:32];
        if (upd) ccm = ef;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        cc_wr = noisy;
        cc_wdata = ~ccm;
        check("ready_fall", {63'd0, ready}, 64'd0);
        lat = 1; seen = 1'b0; busy_ready = 0;
        while (!seen && lat <= 40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                lat++;
                if (ready) busy_ready++;
            end
        end
        start = 1'b0;
        cc_wr = 1'b0;
        check("done_seen", {63'd0, seen}, 64'd1);
        check("busy_ready_low", 64'(busy_ready), 64'd0);
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", {32'd0, result}, {32'd0, er});
        check("cc", {60'd0, cc}, {60'd0, ccm});
        res_o = result;
        lat_o = lat;
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("ready_back", {63'd0, ready}, 64'd1);
        check("result_held", {32'd0, result}, {32'd0, er});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ccm = 4'd0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          lat;
        int          dones;
        logic [3:0]  ro;
        reset = 1'b1; start = 1'b0; op = 4'd0; opa = '0; opb = '0; shamt = '0;
        update_cc = 1'b0; cc_wr = 1'b0; cc_wdata = '0;
        ccm = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_ready",  {63'd0, ready}, 64'd1);
        check("rst_done",   {63'd0, done}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_cc",     {60'd0, cc}, 64'd0);
        check("rst_alu_op", {60'd0, alu_op}, 64'd15);
        check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        check("rst_cin",    {63'd0, alu_cin}, 64'd0);

        // ADD overflow into the sign bit
        do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, r, lat);
        check("add_const", {32'd0, r}, 64'h8000_0000);
        check("add_N", {63'd0, cc[2]}, 64'd1);
        check("add_Z", {63'd0, cc[0]}, 64'd0);

        // Direct carry load then ADDC without and with flag commit
        @(negedge clk);
        cc_wr = 1'b1; cc_wdata = 4'b1000;
        @(negedge clk);
        cc_wr = 1'b0; ccm = 4'b1000;
        check("cc_wr", {60'd0, cc}, 64'h8);
        do_op(4'd1, 32'd5, 32'd6, 0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, r, lat);
        check("addc_const", {32'd0, r}, 64'd12);
        check("addc_cc_kept", {60'd0, cc}, 64'h8);
        do_op(4'd1, 32'd5, 32'd6, 0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, r, lat);
        check("addc_const2", {32'd0, r}, 64'd12);

        // Carry written in the accept cycle feeds the same ADDC
        do_op(4'd1, 32'd1, 32'd1, 0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, r, lat);
        check("addc_wr_same", {32'd0, r}, 64'd3);

        // Multi-position shifts
        do_op(4'd9, 32'h0000_0001, 32'd0, 4, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, r, lat);
        check("lsl4_const", {32'd0, r}, 64'h10);
        check("lsl4_lat", 64'(lat), 64'd5);
        do_op(4'd12, 32'h0000_0001, 32'd0, 1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, r, lat);
        check("rr1_const", {32'd0, r}, 64'h8000_0000);

        // Shift by zero behaves as PASS
        do_op(4'd9, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, r, lat);
        check("lsl0_const", {32'd0, r}, 64'hDEAD_BEEF);
        check("lsl0_lat", 64'(lat), 64'd2);

        // start held throughout RL 31, with ignored cc_wr noise
        a = $urandom;
        do_op(4'd11, a, 32'd0, 31, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, r, lat);
        check("rl31_is_rr1", {32'd0, r}, {32'd0, a[0], a[31:1]});

        // Random operations
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            do_op(ro, $urandom, $urandom, $urandom_range(0, 9), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 4'($urandom), 1'b0, 1'($urandom), r, lat);
        end

        // Reset in the middle of a long LSR: abort, no done, cc untouched
        do_reset();
        @(negedge clk);
        start = 1'b1; op = 4'd10; opa = $urandom; opb = '0; shamt = 5'd20; update_cc = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("iter_busy", {63'd0, ready}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready",  {63'd0, ready}, 64'd1);
        check("abort_done",   {63'd0, done}, 64'd0);
        check("abort_cc",     {60'd0, cc}, 64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_cc_late", {60'd0, cc}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
